// File: rtl/tuner_pkg.sv
// rtl/tuner_pkg.sv - shared types and default constants for the channel tuner
package tuner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    APPLY = 2'd2
  } state_t;

  // K for channel 0: 2^32 * 87.5 MHz / 240 MHz
  localparam logic [31:0] K_BASE_DEF   = 32'd1565873493;
  // K increment per 100 kHz channel step
  localparam logic [31:0] K_STEP_DEF   = 32'd1789570;
  localparam int          NCH_DEF      = 206;
  localparam int          CH_RESET_DEF = 125;

  // Autorepeat timing in en_tick periods: 0.5 s initial delay, then 100 ms
  localparam int REPEAT_DELAY = 16000;
  localparam int REPEAT_RATE  = 3200;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - button synchronizer, debouncer and press-event generator (AUTOREPEAT_EN adds hold-to-repeat)
module key_debounce
  import tuner_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 640
) (
  input  logic clk,
  input  logic reset,
  input  logic en_tick,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          fall;

  // Two-flop synchronizer; idle level is released (high)
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Flip the stable level after DEBOUNCE_TICKS consecutive disagreeing ticks; emit a pulse on press
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b1;
      cnt    <= '0;
      fall   <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (en_tick) begin
        if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
          stable <= ~stable;
          cnt    <= '0;
          fall   <= stable;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_armed;
  logic          rpt_ev;

  // While held, fire after the initial delay and then at the repeat rate
  always_ff @(posedge clk) begin
    if (reset || stable) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
      rpt_ev    <= 1'b0;
    end else begin
      rpt_ev <= 1'b0;
      if (en_tick) begin
        if (rpt_cnt == RW'(rpt_armed ? REPEAT_RATE - 1 : REPEAT_DELAY - 1)) begin
          rpt_ev    <= 1'b1;
          rpt_armed <= 1'b1;
          rpt_cnt   <= '0;
        end else begin
          rpt_cnt <= rpt_cnt + 1'b1;
        end
      end
    end
  end

  assign press = fall | rpt_ev;
`else
  assign press = fall;
`endif

endmodule

// File: rtl/tuner_ctrl.sv
// rtl/tuner_ctrl.sv - channel up/down control and DDS tuning word update on en_tick (AUTOREPEAT_EN enables key repeat)
module tuner_ctrl
  import tuner_pkg::*;
#(
  parameter int                   width_dds      = 32,
  parameter int                   width_ch       = 8,
  parameter int                   NCH            = NCH_DEF,
  parameter int                   CH_RESET       = CH_RESET_DEF,
  parameter logic [width_dds-1:0] K_BASE         = width_dds'(K_BASE_DEF),
  parameter logic [width_dds-1:0] K_STEP         = width_dds'(K_STEP_DEF),
  parameter int                   DEBOUNCE_TICKS = 640
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_tick,
  input  logic                 key_up_n,
  input  logic                 key_dn_n,
  output logic [width_dds-1:0] K,
  output logic [width_ch-1:0]  ch,
  output logic                 k_update,
  output logic                 busy
);

  localparam int                  IW      = $clog2(width_ch);
  localparam logic [width_ch-1:0] CH_LAST = width_ch'(NCH - 1);

  logic                 up_ev;
  logic                 dn_ev;
  state_t               state;
  logic [width_dds-1:0] acc;
  logic [IW-1:0]        bit_idx;

  key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_key_up (
    .clk     (clk),
    .reset   (reset),
    .en_tick (en_tick),
    .key_n   (key_up_n),
    .press   (up_ev)
  );

  key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_key_dn (
    .clk     (clk),
    .reset   (reset),
    .en_tick (en_tick),
    .key_n   (key_dn_n),
    .press   (dn_ev)
  );

  // Retune sequencer: step channel, shift-add K_BASE + ch*K_STEP, publish K on an en_tick
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CALC;
      ch       <= width_ch'(CH_RESET);
      K        <= K_BASE;
      acc      <= K_BASE;
      bit_idx  <= '0;
      k_update <= 1'b0;
      busy     <= 1'b1;
    end else begin
      k_update <= 1'b0;
      unique case (state)
        IDLE: begin
          // simultaneous up and down cancel each other
          if (up_ev ^ dn_ev) begin
            if (up_ev) ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
            else       ch <= (ch == '0) ? CH_LAST : ch - 1'b1;
            acc     <= K_BASE;
            bit_idx <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (ch[bit_idx]) acc <= acc + (K_STEP << bit_idx);
          if (bit_idx == IW'(width_ch - 1)) state <= APPLY;
          else                              bit_idx <= bit_idx + 1'b1;
        end
        APPLY: begin
          // only change K on a sample boundary of radio_core
          if (en_tick) begin
            K        <= acc;
            k_update <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tuner_ctrl.sv
// tb/tb_tuner_ctrl.sv - self-checking bench for tuner_ctrl against a behavioural model (AUTOREPEAT_EN adds a hold test)
module tb_tuner_ctrl;
  import tuner_pkg::*;

  localparam int DT    = 20;
  localparam int NCHAN = 206;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_tick = 1'b0;
  logic        key_up_n = 1'b1;
  logic        key_dn_n = 1'b1;
  logic [31:0] K;
  logic [7:0]  ch;
  logic        k_update;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int kupd_seen = 0;
  bit check_en = 1'b0;
  int tick_period = 4;
  int tick_div = 0;
  int kb;

  tuner_ctrl #(.DEBOUNCE_TICKS(DT)) dut (
    .clk      (clk),
    .reset    (reset),
    .en_tick  (en_tick),
    .key_up_n (key_up_n),
    .key_dn_n (key_dn_n),
    .K        (K),
    .ch       (ch),
    .k_update (k_update),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // model state
  int          m_ch;
  logic [31:0] m_K;
  bit          m_kupd;
  bit          m_busy;
  int          m_calc;
  bit          m_d1[2];
  bit          m_d2[2];
  bit          m_st[2];
  bit          m_press[2];
  int          m_run[2];
`ifdef AUTOREPEAT_EN
  int          m_rpt[2];
  bit          m_armed[2];
`endif

  function automatic logic [31:0] k_of(int c);
    longint unsigned v;
    v = 64'd1565873493 + longint'(c) * 64'd1789570;
    return v[31:0];
  endfunction

  function automatic void key_step(int k, bit raw);
    bit fall;
    bit rep;
    fall = 1'b0;
    rep  = 1'b0;
`ifdef AUTOREPEAT_EN
    if (m_st[k]) begin
      m_rpt[k]   = 0;
      m_armed[k] = 1'b0;
    end else if (en_tick) begin
      m_rpt[k]++;
      if (m_rpt[k] == (m_armed[k] ? REPEAT_RATE : REPEAT_DELAY)) begin
        rep        = 1'b1;
        m_armed[k] = 1'b1;
        m_rpt[k]   = 0;
      end
    end
`endif
    if (m_d2[k] == m_st[k]) m_run[k] = 0;
    else if (en_tick) begin
      m_run[k]++;
      if (m_run[k] == DT) begin
        fall     = m_st[k];
        m_st[k]  = !m_st[k];
        m_run[k] = 0;
      end
    end
    m_press[k] = fall | rep;
    m_d2[k] = m_d1[k];
    m_d1[k] = raw;
  endfunction

  always @(posedge clk) begin : model
    bit ev_up;
    bit ev_dn;
    if (reset) begin
      m_ch = 125; m_K = 32'd1565873493; m_kupd = 1'b0; m_busy = 1'b1; m_calc = 8;
      for (int k = 0; k < 2; k++) begin
        m_d1[k] = 1'b1; m_d2[k] = 1'b1; m_st[k] = 1'b1; m_press[k] = 1'b0; m_run[k] = 0;
`ifdef AUTOREPEAT_EN
        m_rpt[k] = 0; m_armed[k] = 1'b0;
`endif
      end
    end else begin
      ev_up  = m_press[0];
      ev_dn  = m_press[1];
      m_kupd = 1'b0;
      if (!m_busy) begin
        if (ev_up != ev_dn) begin
          if (ev_up) m_ch = (m_ch == NCHAN - 1) ? 0 : m_ch + 1;
          else       m_ch = (m_ch == 0) ? NCHAN - 1 : m_ch - 1;
          m_busy = 1'b1;
          m_calc = 8;
        end
      end else if (m_calc > 0) begin
        m_calc--;
      end else if (en_tick) begin
        m_K    = k_of(m_ch);
        m_kupd = 1'b1;
        m_busy = 1'b0;
      end
      key_step(0, key_up_n);
      key_step(1, key_dn_n);
    end
  end

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("K", longint'(K), longint'(m_K));
      chk("ch", longint'(ch), longint'(m_ch));
      chk("k_update", longint'(k_update), longint'(m_kupd));
      chk("busy", longint'(busy), longint'(m_busy));
      if (k_update) kupd_seen++;
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      en_tick  = (tick_period != 0) && (tick_div == 0);
      tick_div = (tick_period == 0) ? 0 : (tick_div + 1) % tick_period;
    end
  endtask

  task automatic set_period(int p);
    tick_period = p;
    tick_div    = 0;
  endtask

  task automatic wait_idle(int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      cyc(1);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, limit);
    end
    cyc(2);
  endtask

  task automatic press(bit up, bit dn, int hold);
    if (up) key_up_n = 1'b0;
    if (dn) key_dn_n = 1'b0;
    cyc(hold);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    cyc(DT + 6);
    wait_idle(200);
  endtask

  initial begin
    reset = 1'b1;
    set_period(4);
    @(posedge clk);
    #1;
    check_en = 1'b1;
    cyc(2);
    chk("rst_ch", longint'(ch), 125);
    chk("rst_K", longint'(K), 1565873493);
    chk("rst_busy", longint'(busy), 1);
    chk("rst_kupd", longint'(k_update), 0);
    reset = 1'b0;
    wait_idle(100);
    chk("boot_K", longint'(K), 1789569743);
    chk("boot_ch", longint'(ch), 125);
    chk("boot_pulses", kupd_seen, 1);

    // press one cycle too short to debounce
    set_period(1);
    press(1'b1, 1'b0, DT - 1);
    chk("short_ch", longint'(ch), 125);
    chk("short_pulses", kupd_seen, 1);

    // three bounces, then a long hold with slow ticks
    set_period(3);
    repeat (3) begin
      key_up_n = 1'b0; cyc(5);
      key_up_n = 1'b1; cyc(5);
    end
    key_up_n = 1'b0;
    cyc(700 * 3);
    key_up_n = 1'b1;
    cyc(3 * DT + 10);
    wait_idle(200);
    chk("bounce_ch", longint'(ch), 126);
    chk("bounce_K", longint'(K), 1791359313);
    chk("bounce_pulses", kupd_seen, 2);

    // climb to the top channel, then wrap both ways
    set_period(1);
    for (int i = 0; i < 79; i++) press(1'b1, 1'b0, DT + 6);
    chk("top_ch", longint'(ch), 205);
    chk("top_K", longint'(K), 1932735343);
    press(1'b1, 1'b0, DT + 6);
    chk("wrap_up_ch", longint'(ch), 0);
    chk("wrap_up_K", longint'(K), 1565873493);
    press(1'b0, 1'b1, DT + 6);
    chk("wrap_dn_ch", longint'(ch), 205);
    chk("wrap_dn_K", longint'(K), 1932735343);

    // both keys together cancel
    kb = kupd_seen;
    press(1'b1, 1'b1, DT + 6);
    chk("both_ch", longint'(ch), 205);
    chk("both_pulses", kupd_seen - kb, 0);

    // second event lands during CALC and is dropped
    kb = kupd_seen;
    key_up_n = 1'b0;
    cyc(3);
    key_dn_n = 1'b0;
    cyc(DT + 8);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    cyc(DT + 8);
    wait_idle(200);
    chk("drop_ch", longint'(ch), 0);
    chk("drop_K", longint'(K), 1565873493);
    chk("drop_pulses", kupd_seen - kb, 1);

    // reset while stalled in APPLY
    key_up_n = 1'b0;
    cyc(DT + 4);
    chk("apply_busy_rise", longint'(busy), 1);
    set_period(0);
    key_up_n = 1'b1;
    cyc(12);
    chk("apply_busy", longint'(busy), 1);
    chk("apply_ch", longint'(ch), 1);
    chk("apply_K_held", longint'(K), 1565873493);
    reset = 1'b1;
    cyc(2);
    chk("rst2_K", longint'(K), 1565873493);
    chk("rst2_ch", longint'(ch), 125);
    reset = 1'b0;
    set_period(1);
    wait_idle(100);
    chk("reboot_K", longint'(K), 1789569743);
    chk("reboot_ch", longint'(ch), 125);

`ifdef AUTOREPEAT_EN
    // hold 0.5 s + 300 ms of ticks past the debounce
    kb = kupd_seen;
    key_up_n = 1'b0;
    cyc(REPEAT_DELAY + 3 * REPEAT_RATE + DT + 10);
    key_up_n = 1'b1;
    cyc(DT + 10);
    wait_idle(200);
    chk("repeat_extra", kupd_seen - kb - 1, 4);
    chk("repeat_ch", longint'(ch), 130);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
